// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants, types and helpers for the BCD display scanner slice.
// Contents: digit geometry, blank code, display limit, digit-index type,
// converter state enum and the per-nibble add-3 adjustment used by the
// double-dabble datapath.
package seg_display_pkg;

  localparam int         NUM_DIGITS  = 4;
  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] BLANK_CODE  = 4'hF;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } conv_state_t;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] bcd_add3(input logic [15:0] bcd_in);
    logic [15:0] res;
    res = bcd_in;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd_in[i*4 +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bus between a value producer and the BCD display scanner.
// Signals: value/load (producer -> scanner), busy/overflow (status back),
// number/anode_selector (multiplexed digit drive toward seven_segment).
// master = producer side, slave = scanner side.
interface bcd_display_scanner_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic        overflow;
  logic [3:0]  number;
  logic [1:0]  anode_selector;

  modport master (output value, load,
                  input  busy, overflow, number, anode_selector);
  modport slave  (input  value, load,
                  output busy, overflow, number, anode_selector);
endinterface

// File: rtl/bcd_display_scanner_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, rst_n (async active-low), start (capture bin when idle),
// bin[BIN_W-1:0], busy (conversion running), done (1-cycle pulse during the
// final cycle), bcd[15:0] (result, valid while done is high).
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int SHIFT_W = 4 * NUM_DIGITS + BIN_W;

  conv_state_t        state_r, state_next_s;
  logic [SHIFT_W-1:0] shift_r, shift_next_s, adj_s, shifted_s;
  logic [3:0]         cnt_r, cnt_next_s;
  logic               done_s;

  // One double-dabble step: add-3 on the BCD part, then shift everything left.
  always_comb begin
    adj_s     = {bcd_add3(shift_r[SHIFT_W-1 -: 16]), shift_r[BIN_W-1:0]};
    shifted_s = {adj_s[SHIFT_W-2:0], 1'b0};
  end

  // Next-state and datapath control for IDLE/CONVERT.
  always_comb begin
    state_next_s = state_r;
    shift_next_s = shift_r;
    cnt_next_s   = cnt_r;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          shift_next_s = {{(4*NUM_DIGITS){1'b0}}, bin};
          cnt_next_s   = 4'd0;
          state_next_s = ST_CONVERT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        shift_next_s = shifted_s;
        cnt_next_s   = cnt_r + 4'd1;
        if (cnt_r == 4'(BIN_W - 1)) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CONVERT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      shift_r <= {SHIFT_W{1'b0}};
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      shift_r <= shift_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign busy = (state_r == ST_CONVERT);
  assign done = done_s;
  // The result is the post-shift value of the final step, so the parent can
  // commit on the same edge that ends the conversion.
  assign bcd  = shifted_s[SHIFT_W-1 -: 16];

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-4-digit display feeder: converts a loaded 14-bit value to BCD,
// commits it (with leading-zero blanking and overflow blanking) to a display
// register and scans the digits out one at a time at a fixed dwell.
// Ports: clk, rst_n (async active-low), bus (slave modport: value, load in;
// busy, overflow, number, anode_selector out).
module bcd_display_scanner
  import seg_display_pkg::*;
#(
  parameter int DIGIT_CYCLES  = 100000,
  parameter int BLANK_LEADING = 1,
  parameter int BIN_W         = 14
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_display_scanner_if.slave bus
);

  localparam int PRESC_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  logic               conv_busy_s, conv_done_s, start_s, adv_s, lead_zero_s;
  digits_t            bcd_s, commit_digits_s, digits_next_s, digits_r;
  logic               ovf_pend_r, overflow_r;
  logic [PRESC_W-1:0] presc_r;
  digit_idx_t         sel_r, sel_next_s;
  logic [3:0]         number_r;

  assign start_s    = bus.load & ~conv_busy_s;
  assign adv_s      = (presc_r == PRESC_W'(DIGIT_CYCLES - 1));
  assign sel_next_s = sel_r + 2'd1;

  bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s),
    .bin   (bus.value),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // Digits to commit: all blank on overflow, otherwise blank zeros above the
  // most significant non-zero digit (the ones digit is always shown).
  always_comb begin
    lead_zero_s     = 1'b1;
    commit_digits_s = bcd_s;
    if (ovf_pend_r) begin
      commit_digits_s = {NUM_DIGITS{BLANK_CODE}};
    end else if (BLANK_LEADING != 0) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        lead_zero_s = lead_zero_s & (bcd_s[i] == 4'd0);
        if (lead_zero_s) begin
          commit_digits_s[i] = BLANK_CODE;
        end else begin
          commit_digits_s[i] = bcd_s[i];
        end
      end
    end else begin
      commit_digits_s = bcd_s;
    end
  end

  // Display contents as of the end of this cycle; the scan mux reads this so
  // a commit and a scan advance on the same edge show the new digit.
  always_comb begin
    if (conv_done_s) begin
      digits_next_s = commit_digits_s;
    end else begin
      digits_next_s = digits_r;
    end
  end

  // Display register, overflow capture at load and overflow flag at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r   <= {NUM_DIGITS{BLANK_CODE}};
      ovf_pend_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      digits_r <= digits_next_s;
      if (start_s) begin
        ovf_pend_r <= (bus.value > MAX_DISPLAY);
      end
      if (conv_done_s) begin
        overflow_r <= ovf_pend_r;
      end
    end
  end

  // Free-running dwell prescaler and digit scan; number and index move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r  <= {PRESC_W{1'b0}};
      sel_r    <= 2'd0;
      number_r <= BLANK_CODE;
    end else if (adv_s) begin
      presc_r  <= {PRESC_W{1'b0}};
      sel_r    <= sel_next_s;
      number_r <= digits_next_s[sel_next_s];
    end else begin
      presc_r  <= presc_r + PRESC_W'(1);
    end
  end

  assign bus.busy           = conv_busy_s;
  assign bus.overflow       = overflow_r;
  assign bus.number         = number_r;
  assign bus.anode_selector = sel_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: two instances (leading-zero
// blanking on and off) receive identical loads; expected digits are queued
// at load time and checked by a monitor when a conversion commits.
module tb_bcd_display_scanner;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scanner_if ifa ();
  bcd_display_scanner_if ifb ();

  bcd_display_scanner #(.DIGIT_CYCLES(DC), .BLANK_LEADING(1), .BIN_W(14)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  bcd_display_scanner #(.DIGIT_CYCLES(DC), .BLANK_LEADING(0), .BIN_W(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  // da/db: digits thousands..ones as hex nibbles for blanking on/off.
  typedef struct packed {
    logic [15:0] da;
    logic [15:0] db;
    logic        ovf;
    logic        scan;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record the number shown at each index across one full scan round.
  task automatic scan_capture(output logic [15:0] ca, output logic [15:0] cb, output bit ok);
    logic [1:0] prev;
    logic [3:0] seen;
    int n, idx;
    ca = 16'h0000; cb = 16'h0000; seen = 4'h0; n = 0;
    prev = ifa.anode_selector;
    while (seen != 4'hF && n < 40) begin
      @(negedge clk);
      n++;
      if (ifa.anode_selector != prev) begin
        idx = int'(ifa.anode_selector);
        ca[idx*4 +: 4] = ifa.number;
        cb[idx*4 +: 4] = ifb.number;
        seen[idx] = 1'b1;
        prev = ifa.anode_selector;
      end
    end
    ok = (seen == 4'hF);
  endtask

  // Monitor: a falling busy outside reset is a commit; pop and compare.
  initial begin
    logic busy_prev;
    logic [15:0] ca, cb;
    bit ok;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !ifa.busy) begin
          mon_active = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual=commit required=none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("overflow_a", {31'd0, ifa.overflow}, {31'd0, e.ovf});
            check("overflow_b", {31'd0, ifb.overflow}, {31'd0, e.ovf});
            if (e.scan) begin
              scan_capture(ca, cb, ok);
              check("scan_round", {31'd0, ok}, 32'd1);
              check("digits_blank", {16'd0, ca}, {16'd0, e.da});
              check("digits_noblank", {16'd0, cb}, {16'd0, e.db});
            end
          end
          mon_active = 1'b0;
        end
        busy_prev = ifa.busy;
      end
    end
  end

  task automatic drive(input logic [13:0] v, input logic ld);
    ifa.value = v; ifb.value = v;
    ifa.load = ld; ifb.load = ld;
  endtask

  // Issue one load and follow busy. inject: ignored loads at busy cycles 1/13.
  // align: start so the commit edge coincides with a scan advance.
  // stop_at: return at that busy cycle (for a mid-conversion reset).
  // immediate: load in the current cycle without waiting a negedge first.
  task automatic run_load(input logic [13:0] v, input bit inject, input bit align,
                          input int stop_at, input bit immediate, input logic [15:0] da);
    int cnt, n;
    logic [1:0] prev, a0;
    if (align) begin
      a0 = ifa.anode_selector; n = 0;
      while (ifa.anode_selector == a0 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
    end else if (!immediate) begin
      @(negedge clk);
    end
    drive(v, 1'b1);
    @(negedge clk);
    drive(v, 1'b0);
    check("busy_after_load", {31'd0, ifa.busy}, 32'd1);
    cnt = 0;
    prev = ifa.anode_selector;
    while (ifa.busy && cnt < 40) begin
      cnt++;
      if (cnt == stop_at) break;
      if (inject && (cnt == 1 || cnt == 13)) drive(14'd5678, 1'b1);
      else drive(v, 1'b0);
      prev = ifa.anode_selector;
      @(negedge clk);
    end
    drive(v, 1'b0);
    if (stop_at == 0) check("busy_cycles", cnt, 32'd14);
    if (align) begin
      check("aligned_advance", {30'd0, ifa.anode_selector}, {30'd0, prev + 2'd1});
      check("aligned_number", {28'd0, ifa.number}, {28'd0, da[int'(ifa.anode_selector)*4 +: 4]});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || mon_active) && n < 100) begin @(negedge clk); n++; end
    check("drain", {31'd0, (exp_q.size() == 0 && !mon_active)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, ifa.busy}, 32'd0);
    check({tag, "_overflow"}, {31'd0, ifa.overflow}, 32'd0);
    check({tag, "_anode"}, {30'd0, ifa.anode_selector}, 32'd0);
    check({tag, "_number"}, {28'd0, ifa.number}, 32'hF);
  endtask

  task automatic check_blank_display(input string tag);
    logic [15:0] ca, cb;
    bit ok;
    @(negedge clk);
    check({tag, "_start_idx"}, {30'd0, ifa.anode_selector}, 32'd0);
    scan_capture(ca, cb, ok);
    check({tag, "_scan"}, {31'd0, ok}, 32'd1);
    check({tag, "_digits_a"}, {16'd0, ca}, 32'hFFFF);
    check({tag, "_digits_b"}, {16'd0, cb}, 32'hFFFF);
  endtask

  typedef struct packed {
    logic [13:0] v;
    logic [15:0] da;
    logic [15:0] db;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    exp_t e;
    vecs[0] = '{v: 14'd1234,  da: 16'h1234, db: 16'h1234, ovf: 1'b0};
    vecs[1] = '{v: 14'd7,     da: 16'hFFF7, db: 16'h0007, ovf: 1'b0};
    vecs[2] = '{v: 14'd0,     da: 16'hFFF0, db: 16'h0000, ovf: 1'b0};
    vecs[3] = '{v: 14'd1005,  da: 16'h1005, db: 16'h1005, ovf: 1'b0};
    vecs[4] = '{v: 14'd9999,  da: 16'h9999, db: 16'h9999, ovf: 1'b0};
    vecs[5] = '{v: 14'd10000, da: 16'hFFFF, db: 16'hFFFF, ovf: 1'b1};
    vecs[6] = '{v: 14'd16383, da: 16'hFFFF, db: 16'hFFFF, ovf: 1'b1};
    vecs[7] = '{v: 14'd42,    da: 16'hFF42, db: 16'h0042, ovf: 1'b0};

    drive(14'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_blank_display("reset_release");

    foreach (vecs[i]) begin
      e = '{da: vecs[i].da, db: vecs[i].db, ovf: vecs[i].ovf, scan: 1'b1};
      exp_q.push_back(e);
      run_load(vecs[i].v, 1'b0, 1'b0, 0, 1'b0, vecs[i].da);
      wait_idle();
    end

    // Loads while busy are ignored.
    exp_q.push_back('{da: 16'h1234, db: 16'h1234, ovf: 1'b0, scan: 1'b1});
    run_load(14'd1234, 1'b1, 1'b0, 0, 1'b0, 16'h1234);
    wait_idle();

    // Back-to-back: a load in the cycle right after busy falls is accepted.
    exp_q.push_back('{da: 16'h8765, db: 16'h8765, ovf: 1'b0, scan: 1'b0});
    run_load(14'd8765, 1'b0, 1'b0, 0, 1'b0, 16'h8765);
    exp_q.push_back('{da: 16'h4321, db: 16'h4321, ovf: 1'b0, scan: 1'b1});
    run_load(14'd4321, 1'b0, 1'b0, 0, 1'b1, 16'h4321);
    wait_idle();

    // Reset mid-conversion aborts without committing.
    run_load(14'd5678, 1'b0, 1'b0, 7, 1'b0, 16'h5678);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_midconv");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_blank_display("after_abort");

    // Commit on the same edge as a scan advance.
    exp_q.push_back('{da: 16'hF321, db: 16'h0321, ovf: 1'b0, scan: 1'b1});
    run_load(14'd321, 1'b0, 1'b1, 0, 1'b0, 16'hF321);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Upstream feeder for the 4-digit seven_segment stage.
- Accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential double-dabble, one bit per cycle.
- Holds the committed digits in a display register and time-multiplexes them, driving `number` and `anode_selector` into seven_segment at a fixed per-digit dwell.
- Provides leading-zero blanking and overflow indication.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit is held before advancing (1 ms at 100 MHz); legal range ≥2.
- BLANK_LEADING, 1, 1 = leading zeros are replaced by blank code 4'hF; 0 = all four digits shown.
- BIN_W, 14, binary input width; fixed at 14, since 2^14-1 covers 9999.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- value  input  14  unsigned binary value to display; sampled only on an accepted load.
- load  input  1  single-cycle strobe; accepted only when busy=0.
- busy  output  1  conversion in progress; display register unchanged while high.
- overflow  output  1  last committed value exceeded 9999.
- number  output  4  digit code to seven_segment.number; 0-9 or 4'hF (blank).
- anode_selector  output  2  digit index to seven_segment.anode_selector; 0 = ones, 3 = thousands.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: busy=0, overflow=0, anode_selector=0, number=4'hF, all four display digits=4'hF, prescaler=0, conversion state idle. Reset mid-conversion aborts it; nothing is committed.
- Accepting a load:
  - load=1 with busy=0 at edge E0 captures value into the shift register, clears the BCD accumulator and sets busy.
  - load while busy=1 is ignored; it is neither queued nor restarts the conversion.
- Conversion:
  - Edges E1..E14: at each edge, every BCD nibble ≥5 gets +3, then the combined 16+14-bit register shifts left by one.
  - At E14 the BCD result is committed to the display register and busy clears.
  - busy is high for exactly BIN_W (14) cycles. New digits are visible on `number` from the next scan update after E14.
- Overflow:
  - Flagged at capture if value > 9999.
  - On commit, overflow=1 and all four display digits become 4'hF.
  - A non-overflowing commit clears overflow.
- Blanking at commit (BLANK_LEADING=1):
  - Digit i (i=3..1) becomes 4'hF if it and every higher digit are zero.
  - Digit 0 is never blanked, so value 0 displays as "   0".
- States: IDLE → (load accepted) CONVERT → (14th shift) IDLE. No other states exist.
- Scan:
  - The prescaler counts 0..DIGIT_CYCLES-1 continuously, independent of busy/load.
  - At the terminal count, the prescaler returns to 0 and anode_selector increments, wrapping 3 → 0.
  - number is registered as display_digit[next anode_selector] on the same edge, so number and anode_selector change together and always stay aligned.
- Commit during scan: if a commit and a scan advance land on the same edge, number shows the newly committed digit for the new index. Torn old/new mixes within one digit are not allowed.

Decomposition:
- Package seg_display_pkg holds:
  - NUM_DIGITS=4
  - BLANK_CODE=4'hF
  - MAX_DISPLAY=9999
  - DIGIT_W=4
  - the digit-index type (2 bits)
- Sub-module bin2bcd_seq:
  - Ports: clk, rst_n, start, bin[13:0], busy, done (1-cycle pulse), bcd[15:0].
  - Owns the shift/add-3 datapath.
- The top level owns commit, blanking, overflow, prescaler and scan mux.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle → immediately busy=0, overflow=0, anode_selector=0, number=4'hF. Hold 4 cycles, release → the scan starts from index 0.
2. Load 1234 (DIGIT_CYCLES=4) → busy high for exactly 14 cycles. Then anode_selector cycles 0,1,2,3,0 every 4 clks with number 4,3,2,1,4; overflow=0.
3. Load 7, BLANK_LEADING=1 → number per index 0..3 is 7,F,F,F. Load 0 → 0,F,F,F. Load 1005 → 5,0,0,1 (interior zeros not blanked). With BLANK_LEADING=0, load 7 → 7,0,0,0.
4. Load 9999 → 9,9,9,9, overflow=0. Load 10000 → overflow=1, all digits F. Load 16383 → same. Then load 42 → overflow=0, digits 2,4,F,F.
5. Load 1234, then pulse load with 5678 at busy cycles 1 and 13 → both ignored, display ends 1234. A load in the cycle after busy falls is accepted.
6. Load 5678, drop rst_n at busy cycle 7 → busy=0 and all digits F after release. A following load 321 → 1,2,3,F. Also cover a commit on the same edge as a scan advance → new digit appears with the new index, no glitch value.
